// File: rtl/tournament_bht_p.sv
// tournament_bht_p
//   Tournament branch predictor. A gshare global PHT, a per-index local
//   history table feeding a local PHT, and a 2-bit chooser indexed by global
//   history. A lookup returns a registered prediction one cycle later. An
//   in-order FIFO of in-flight contexts lets each resolution train exactly the
//   entries that produced its prediction. On a mispredict the FIFO is flushed
//   and the speculative global history is repaired.
//
//   Ports
//     clk_i, reset_i      clock, synchronous active-high reset
//     r_v_i, idx_r_i      lookup request (accepted when ready_o=1)
//     ready_o             context FIFO not full and no mispredict repair now
//     predict_v_o         prediction valid (lookup accepted last cycle)
//     predict_o           1 = taken, 0 whenever predict_v_o=0
//     w_v_i, idx_w_i      resolution of the oldest in-flight branch
//     correct_i           1 = that branch's prediction was correct
//     err_o               1-cycle pulse: resolve on empty FIFO or idx mismatch
module tournament_bht_p #(
  parameter int idx_width_p   = 9,
  parameter int ghist_width_p = 12,
  parameter int lhist_width_p = 10,
  parameter int ctr_width_p   = 2,
  parameter int inflight_p    = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     r_v_i,
  input  logic [idx_width_p-1:0]   idx_r_i,
  output logic                     ready_o,
  output logic                     predict_v_o,
  output logic                     predict_o,
  input  logic                     w_v_i,
  input  logic [idx_width_p-1:0]   idx_w_i,
  input  logic                     correct_i,
  output logic                     err_o
);

  localparam int          ptr_w      = $clog2(inflight_p);
  localparam int unsigned lht_depth  = 2 ** idx_width_p;
  localparam int unsigned lpht_depth = 2 ** lhist_width_p;
  localparam int unsigned g_depth    = 2 ** ghist_width_p;
  localparam logic [ctr_width_p-1:0] ctr_weak_t = {1'b1, {(ctr_width_p-1){1'b0}}};
  localparam logic [ctr_width_p-1:0] ctr_weak_l = ctr_weak_t - 1'b1;
  localparam logic [ptr_w:0]         count_full = (ptr_w+1)'(inflight_p);

  // Prediction tables
  logic [lhist_width_p-1:0] lht     [lht_depth];
  logic [ctr_width_p-1:0]   lpht    [lpht_depth];
  logic [ctr_width_p-1:0]   gpht    [g_depth];
  logic [ctr_width_p-1:0]   chooser [g_depth];
  logic [ghist_width_p-1:0] ghr_spec;

  // In-flight context FIFO
  logic [idx_width_p-1:0]   f_idx   [inflight_p];
  logic [ghist_width_p-1:0] f_ghist [inflight_p];
  logic [lhist_width_p-1:0] f_lh    [inflight_p];
  logic                     f_lp    [inflight_p];
  logic                     f_gp    [inflight_p];
  logic                     f_fin   [inflight_p];
  logic [ptr_w-1:0]         rd_ptr, wr_ptr;
  logic [ptr_w:0]           count;

  logic                     empty, full, pop, mispredict, accept;
  logic [lhist_width_p-1:0] lk_lh;
  logic [ghist_width_p-1:0] lk_gidx;
  logic                     lk_lp, lk_gp, lk_sel, lk_final;
  logic [idx_width_p-1:0]   h_idx;
  logic [ghist_width_p-1:0] h_ghist, h_gidx;
  logic [lhist_width_p-1:0] h_lh;
  logic                     h_lp, h_gp, h_fin, h_taken;

  function automatic logic [ctr_width_p-1:0] sat_upd(input logic [ctr_width_p-1:0] c,
                                                     input logic up);
    if (up) return (c == '1) ? c : c + 1'b1;
    else    return (c == '0) ? c : c - 1'b1;
  endfunction

  always_comb begin
    empty      = (count == '0);
    full       = (count == count_full);
    pop        = w_v_i & ~empty;
    mispredict = pop & ~correct_i;
    // Full is judged on the registered count, so a same-cycle pop does not free a slot.
    ready_o    = ~full & ~mispredict;
    accept     = r_v_i & ready_o;

    lk_lh    = lht[idx_r_i];
    lk_lp    = lpht[lk_lh][ctr_width_p-1];
    lk_gidx  = ghr_spec ^ ghist_width_p'(idx_r_i);
    lk_gp    = gpht[lk_gidx][ctr_width_p-1];
    lk_sel   = chooser[ghr_spec][ctr_width_p-1];
    lk_final = lk_sel ? lk_gp : lk_lp;

    h_idx   = f_idx[rd_ptr];
    h_ghist = f_ghist[rd_ptr];
    h_lh    = f_lh[rd_ptr];
    h_lp    = f_lp[rd_ptr];
    h_gp    = f_gp[rd_ptr];
    h_fin   = f_fin[rd_ptr];
    h_taken = h_fin ^ ~correct_i;
    h_gidx  = h_ghist ^ ghist_width_p'(h_idx);
  end

  // Table training from the FIFO head (non-speculative)
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < lht_depth; i++)  lht[i]  <= '0;
      for (int unsigned i = 0; i < lpht_depth; i++) lpht[i] <= ctr_weak_t;
      for (int unsigned i = 0; i < g_depth; i++) begin
        gpht[i]    <= ctr_weak_t;
        chooser[i] <= ctr_weak_l;
      end
    end else if (pop) begin
      lpht[h_lh]   <= sat_upd(lpht[h_lh], h_taken);
      gpht[h_gidx] <= sat_upd(gpht[h_gidx], h_taken);
      if (h_lp != h_gp)
        chooser[h_ghist] <= sat_upd(chooser[h_ghist], h_gp == h_taken);
      lht[h_idx] <= {lht[h_idx][lhist_width_p-2:0], h_taken};
    end
  end

  // Context FIFO payload (no reset needed; guarded by count)
  always_ff @(posedge clk_i) begin
    if (accept) begin
      f_idx[wr_ptr]   <= idx_r_i;
      f_ghist[wr_ptr] <= ghr_spec;
      f_lh[wr_ptr]    <= lk_lh;
      f_lp[wr_ptr]    <= lk_lp;
      f_gp[wr_ptr]    <= lk_gp;
      f_fin[wr_ptr]   <= lk_final;
    end
  end

  // Pointers, speculative history and registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ghr_spec    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      predict_v_o <= 1'b0;
      predict_o   <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      predict_v_o <= accept;
      predict_o   <= accept & lk_final;
      err_o       <= w_v_i & (empty | (idx_w_i != h_idx));
      if (mispredict) begin
        // Everything younger than the head is wrong-path: drop it and rebuild history.
        ghr_spec <= {h_ghist[ghist_width_p-2:0], h_taken};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (accept) begin
          ghr_spec <= {ghr_spec[ghist_width_p-2:0], lk_final};
          wr_ptr   <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({accept, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tournament_bht_p.sv
module tb_tournament_bht_p;

  localparam int IW = 9, GW = 12, LW = 10, CW = 2, INF = 4;
  localparam int LD = 2 ** IW, PD = 2 ** LW, GD = 2 ** GW;
  localparam int HALF = 2 ** (CW - 1), CMAX = 2 ** CW - 1;

  logic clk = 1'b0;
  logic reset_i, r_v_i, w_v_i, correct_i;
  logic [IW-1:0] idx_r_i, idx_w_i;
  logic ready_o, predict_v_o, predict_o, err_o;

  tournament_bht_p #(.idx_width_p(IW), .ghist_width_p(GW), .lhist_width_p(LW),
                     .ctr_width_p(CW), .inflight_p(INF)) dut (
    .clk_i(clk), .reset_i(reset_i), .r_v_i(r_v_i), .idx_r_i(idx_r_i),
    .ready_o(ready_o), .predict_v_o(predict_v_o), .predict_o(predict_o),
    .w_v_i(w_v_i), .idx_w_i(idx_w_i), .correct_i(correct_i), .err_o(err_o));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_en = 0;
  bit last_ready;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int idx; int ghist; int lh; bit lp; bit gp; bit fin; } ctx_t;
  int   m_lht[LD], m_lpht[PD], m_gpht[GD], m_cho[GD];
  int   m_ghr;
  ctx_t q[$];
  bit   e_pv, e_p, e_err;

  function automatic int sat(input int c, input bit up);
    if (up) return (c < CMAX) ? c + 1 : c;
    return (c > 0) ? c - 1 : c;
  endfunction

  always @(posedge clk) begin : model
    bit mis, rdy, acc, lp, gp, fin, taken, err;
    int lh, gidx;
    ctx_t h, c;
    if (reset_i) begin
      for (int i = 0; i < LD; i++) m_lht[i] = 0;
      for (int i = 0; i < PD; i++) m_lpht[i] = HALF;
      for (int i = 0; i < GD; i++) begin m_gpht[i] = HALF; m_cho[i] = HALF - 1; end
      q.delete();
      m_ghr = 0; e_pv = 0; e_p = 0; e_err = 0;
    end else begin
      mis = w_v_i && q.size() > 0 && !correct_i;
      rdy = q.size() < INF && !mis;
      acc = r_v_i && rdy;
      lh = m_lht[int'(idx_r_i)];
      lp = m_lpht[lh] >= HALF;
      gidx = (m_ghr ^ int'(idx_r_i)) % GD;
      gp = m_gpht[gidx] >= HALF;
      fin = (m_cho[m_ghr] >= HALF) ? gp : lp;
      err = w_v_i && (q.size() == 0 || q[0].idx != int'(idx_w_i));
      if (w_v_i && q.size() > 0) begin
        h = q.pop_front();
        taken = correct_i ? h.fin : !h.fin;
        m_lpht[h.lh] = sat(m_lpht[h.lh], taken);
        gidx = (h.ghist ^ h.idx) % GD;
        m_gpht[gidx] = sat(m_gpht[gidx], taken);
        if (h.lp != h.gp) m_cho[h.ghist] = sat(m_cho[h.ghist], h.gp == taken);
        m_lht[h.idx] = (m_lht[h.idx] * 2 + int'(taken)) % PD;
        if (mis) begin
          m_ghr = (h.ghist * 2 + int'(taken)) % GD;
          q.delete();
        end
      end
      if (acc) begin
        c.idx = int'(idx_r_i); c.ghist = m_ghr; c.lh = lh; c.lp = lp; c.gp = gp; c.fin = fin;
        q.push_back(c);
        m_ghr = (m_ghr * 2 + int'(fin)) % GD;
      end
      e_pv = acc; e_p = acc && fin; e_err = err;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en && !reset_i) begin
      chk("predict_v", int'(predict_v_o), int'(e_pv));
      chk("predict", int'(predict_o), int'(e_p));
      chk("err", int'(err_o), int'(e_err));
      chk("ready", int'(ready_o),
          int'(q.size() < INF && !(w_v_i && q.size() > 0 && !correct_i)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit rv, input int ir, input bit wv, input int iw, input bit cor);
    r_v_i = rv; idx_r_i = IW'(ir); w_v_i = wv; idx_w_i = IW'(iw); correct_i = cor;
    #1 last_ready = ready_o;
    @(posedge clk); #2;
  endtask

  task automatic resolve(input bit rv, input int ir, input int iw, input bit outcome);
    bit cor;
    cor = (q.size() > 0) ? (q[0].fin == outcome) : 1'b1;
    cyc(rv, ir, 1'b1, iw, cor);
  endtask

  task automatic do_reset();
    reset_i = 1; r_v_i = 0; w_v_i = 0; idx_r_i = '0; idx_w_i = '0; correct_i = 0;
    @(posedge clk); #2;
    reset_i = 0;
  endtask

  initial begin
    reset_i = 1; r_v_i = 0; w_v_i = 0; idx_r_i = '0; idx_w_i = '0; correct_i = 0;
    repeat (2) @(posedge clk);
    #2 reset_i = 0;
    chk_en = 1;
    chk("reset_pv", int'(predict_v_o), 0);
    chk("reset_ready", int'(ready_o), 1);

    // 1: first lookup, local side wins with weakly-taken counter
    cyc(1, 5, 0, 0, 0);
    chk("t1_pred_v", int'(predict_v_o), 1);
    chk("t1_pred", int'(predict_o), 1);
    chk("t1_ghr_model", m_ghr, 1);
    chk("t1_ghr_dut", int'(dut.ghr_spec), 1);

    // 2: idx 5 resolves not-taken twice; counters walk down to 0
    resolve(0, 0, 5, 0);
    cyc(1, 5, 0, 0, 0);
    chk("t2_pred_mid", int'(predict_o), 0);
    resolve(0, 0, 5, 0);
    chk("t2_lpht0", m_lpht[0], 0);
    chk("t2_lht5", m_lht[5], 0);
    cyc(1, 5, 0, 0, 0);
    chk("t2_pred", int'(predict_o), 0);
    resolve(0, 0, 5, 0);

    // 3: alternating T/N on idx 3
    do_reset();
    for (int i = 0; i < 200; i++) begin
      bit p;
      cyc(1, 3, 0, 0, 0);
      p = predict_o;
      if (i >= 150) chk("t3_alt", int'(p), i % 2);
      resolve(0, 0, 3, (i % 2) != 0);
    end

    // 4: fill FIFO, ignored 5th lookup, mispredict on 2nd oldest
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1, i, 0, 0, 0);
    chk("t4_full_ready", int'(ready_o), 0);
    cyc(1, 5, 0, 0, 0);
    chk("t4_ign_ready", int'(last_ready), 0);
    chk("t4_ign_pv", int'(predict_v_o), 0);
    resolve(0, 0, 1, 1);
    resolve(1, 6, 2, 0);
    chk("t4_mis_ready", int'(last_ready), 0);
    chk("t4_mis_pv", int'(predict_v_o), 0);
    chk("t4_q_empty", q.size(), 0);
    chk("t4_ghr_model", m_ghr, 2);
    chk("t4_ghr_dut", int'(dut.ghr_spec), 2);
    cyc(0, 0, 0, 0, 0);
    chk("t4_ready_back", int'(last_ready), 1);

    // 5: resolve on empty FIFO, then index mismatch
    do_reset();
    cyc(0, 0, 1, 3, 1);
    chk("t5_err_empty", int'(err_o), 1);
    chk("t5_ghr", int'(dut.ghr_spec), 0);
    cyc(0, 0, 0, 0, 0);
    chk("t5_err_clear", int'(err_o), 0);
    cyc(1, 2, 0, 0, 0);
    resolve(0, 0, 7, 1);
    chk("t5_err_idx", int'(err_o), 1);
    chk("t5_lht2_model", m_lht[2], 1);
    chk("t5_lht2_dut", int'(dut.lht[2]), 1);

    // 6: reset with three in flight
    do_reset();
    for (int i = 1; i <= 3; i++) cyc(1, i, 0, 0, 0);
    do_reset();
    chk("t6_pv", int'(predict_v_o), 0);
    chk("t6_ready", int'(ready_o), 1);
    chk("t6_ghr", int'(dut.ghr_spec), 0);

    // Mixed traffic: concurrent lookup/resolve, full with pop, flushes
    for (int i = 0; i < 120; i++) begin
      bit rv, outc;
      int iw;
      rv = (i % 4) != 3;
      outc = ((i * 5) % 3) == 0;
      iw = (q.size() > 0) ? q[0].idx : 0;
      if (i % 11 == 5) iw = 9;
      if (q.size() > 0 && (i % 4) == 0) resolve(rv, (i * 7) % 16, iw, outc);
      else cyc(rv, (i * 7) % 16, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
